// File: rtl/posit_defines.sv
// Shared widths, latency and sequencer state type for the es=2 posit product
// accumulation path.
package posit_defines;

  // Serialized formats: bit 0 is the zero flag in both.
  localparam int POSIT_SERIALIZED_WIDTH_PRODUCT_ES2    = 32;
  localparam int POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES2 = 48;
  localparam int ACCUM_PROD_LAT_ES2                    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FEED   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4
  } accum_seq_state_t;

  function automatic logic [POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES2-1:0] accum_zero_result();
    return {{(POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES2-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/posit_accum_seq_16.sv
// Sequencer that clears the es=2 product accumulator, feeds N products into its
// single live feedback slot, and returns the drained sum with a sticky truncation flag.
module posit_accum_seq_16
  import posit_defines::*;
#(
  parameter int ACC_LAT = ACCUM_PROD_LAT_ES2,
  parameter int LEN_W   = 16
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             cmd_valid,
  output logic                                             cmd_ready,
  input  logic [LEN_W-1:0]                                 cmd_len,
  input  logic                                             prod_valid,
  output logic                                             prod_ready,
  input  logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES2-1:0]    prod_data,
  output logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES2-1:0]    acc_in1,
  output logic                                             acc_start,
  output logic                                             acc_rst,
  input  logic [POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES2-1:0] acc_result,
  input  logic                                             acc_done,
  input  logic                                             acc_truncated,
  output logic                                             res_valid,
  input  logic                                             res_ready,
  output logic [POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES2-1:0] res_data,
  output logic                                             res_truncated
);

  localparam int SLOT_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(ACC_LAT - 1);

  accum_seq_state_t state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  done_q, done_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              clear_q, clear_d;
  logic              sticky_q, sticky_d;
  logic [POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES2-1:0] res_data_q, res_data_d;

  logic prod_ready_s;
  logic issue_s;
  logic done_s;
  logic last_done_s;

  // Handshake qualifiers and next-state computation for FSM, slot and counters.
  always_comb begin
    prod_ready_s = (state_q == ST_FEED) && (slot_q == {SLOT_W{1'b0}}) && (issued_q < len_q);
    issue_s      = prod_ready_s && prod_valid;
    done_s       = acc_done && ((state_q == ST_FEED) || (state_q == ST_DRAIN));
    last_done_s  = done_s && ((done_q + LEN_W'(1)) == len_q);

    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    res_data_d = res_data_q;
    clear_d    = 1'b0;
    done_d     = done_s ? (done_q + LEN_W'(1)) : done_q;
    sticky_d   = done_s ? (sticky_q | acc_truncated) : sticky_q;

    // Slot 0 is the only live feedback slot; realign it as the clear pulse ends.
    if ((state_q == ST_CLEAR) || (slot_q == SLOT_LAST)) begin
      slot_d = {SLOT_W{1'b0}};
    end else begin
      slot_d = slot_q + SLOT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          len_d    = cmd_len;
          issued_d = {LEN_W{1'b0}};
          done_d   = {LEN_W{1'b0}};
          sticky_d = 1'b0;
          clear_d  = 1'b1;
          state_d  = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (len_q == {LEN_W{1'b0}}) begin
          res_data_d = accum_zero_result();
          state_d    = ST_RESULT;
        end else begin
          state_d = ST_FEED;
        end
      end
      ST_FEED: begin
        if (issue_s) begin
          issued_d = issued_q + LEN_W'(1);
          state_d  = ((issued_q + LEN_W'(1)) == len_q) ? ST_DRAIN : ST_FEED;
        end else begin
          state_d = ST_FEED;
        end
      end
      ST_DRAIN: begin
        if (last_done_s) begin
          res_data_d = acc_result;
          state_d    = ST_RESULT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, counters, clear pulse and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= {LEN_W{1'b0}};
      issued_q   <= {LEN_W{1'b0}};
      done_q     <= {LEN_W{1'b0}};
      slot_q     <= {SLOT_W{1'b0}};
      clear_q    <= 1'b0;
      sticky_q   <= 1'b0;
      res_data_q <= {POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES2{1'b0}};
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      done_q     <= done_d;
      slot_q     <= slot_d;
      clear_q    <= clear_d;
      sticky_q   <= sticky_d;
      res_data_q <= res_data_d;
    end
  end

  // The accumulator has no stall, so the issue strobe follows the handshake directly.
  assign cmd_ready     = (state_q == ST_IDLE) && !rst;
  assign prod_ready    = prod_ready_s;
  assign acc_start     = issue_s;
  assign acc_in1       = prod_data;
  assign acc_rst       = rst | clear_q;
  assign res_valid     = (state_q == ST_RESULT);
  assign res_data      = res_data_q;
  assign res_truncated = sticky_q;

endmodule
